// File: rtl/stack_mem_pkg.sv
// Shared types and constants for the stack data-memory stage.
package stack_mem_pkg;

  // Operation codes presented on op_code.
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_PUSH  = 4'd3,
    OP_POP   = 4'd4,
    OP_CALL  = 4'd5,
    OP_RET   = 4'd6,
    OP_INT   = 4'd7,
    OP_RTI   = 4'd8
  } op_e;

  // Frame sequencer states; IDLE issues word 0 of every op.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUSH1 = 3'd1,
    ST_PUSH2 = 3'd2,
    ST_POP1  = 3'd3,
    ST_POP2  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Meaning of the RAM read data arriving in the following cycle.
  typedef enum logic [2:0] {
    TAG_NONE   = 3'd0,
    TAG_RDATA  = 3'd1,
    TAG_CCR    = 3'd2,
    TAG_LO     = 3'd3,
    TAG_HI     = 3'd4,
    TAG_HI_CCR = 3'd5
  } tag_e;

  // Number of RAM words moved by each stack op.
  localparam logic [1:0] LEN_PUSH = 2'd1;
  localparam logic [1:0] LEN_POP  = 2'd1;
  localparam logic [1:0] LEN_CALL = 2'd2;
  localparam logic [1:0] LEN_RET  = 2'd2;
  localparam logic [1:0] LEN_INT  = 2'd3;
  localparam logic [1:0] LEN_RTI  = 2'd3;

endpackage

// File: rtl/data_ram.sv
// Single-port-write / single-port-read synchronous RAM, contents not reset.
module data_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write on we, register read data on re (holds otherwise).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stack_data_memory.sv
// Data-memory stage: LOAD/STORE plus a hardware stack with CALL/RET/INT/RTI frames.
module stack_data_memory
  import stack_mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int CCR_W   = 3,
  parameter int SP_INIT = 2048,
  localparam int PC_W   = 2*DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [CCR_W-1:0]  ccr_in,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_out_valid,
  output logic [CCR_W-1:0]  ccr_out,
  output logic              ccr_out_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam logic [ADDR_W-1:0] SP_RST = SP_INIT[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   SP_LIM = SP_INIT[ADDR_W:0];
  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Room for n words below SP (SP >= n-1), evaluated without wrap.
  function automatic logic push_ok(input logic [ADDR_W-1:0] sp, input logic [1:0] n);
    return {1'b0, sp} >= ({{(ADDR_W-1){1'b0}}, n} - {{ADDR_W{1'b0}}, 1'b1});
  endfunction

  // n words present above SP (SP + n <= SP_INIT), evaluated without wrap.
  function automatic logic pop_ok(input logic [ADDR_W-1:0] sp, input logic [1:0] n);
    return ({1'b0, sp} + {{(ADDR_W-1){1'b0}}, n}) <= SP_LIM;
  endfunction

  state_e              state_r, state_nxt_s;
  tag_e                tag_r, tag_nxt_s;
  logic [ADDR_W-1:0]   sp_r, sp_nxt_s, sp_up_s;
  logic                ready_r, ovf_r, unf_r;
  logic                ram_we_s, ram_re_s, accept_s, ovf_set_s, unf_set_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_wdata_s, ram_q_s;
  logic                int_frame_r;
  logic [DATA_W-1:0]   pc_lo_r, rd_lo_r, rdata_hold_r;
  logic [CCR_W-1:0]    ccr_r, ccr_stage_r, ccr_hold_r;
  logic [PC_W-1:0]     pc_hold_r;
  logic                rdata_valid_r, pc_valid_r, ccr_valid_r;

  assign sp_up_s = sp_r + SP_ONE;

  data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_addr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (ram_addr_s),
    .rdata (ram_q_s)
  );

  // Next-state, RAM command and SP update for the word issued this cycle.
  always_comb begin
    state_nxt_s = state_r;
    tag_nxt_s   = TAG_NONE;
    sp_nxt_s    = sp_r;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_addr_s  = sp_r;
    ram_wdata_s = {DATA_W{1'b0}};
    accept_s    = 1'b0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_valid) begin
          accept_s = 1'b1;
          case (op_e'(op_code))
            OP_LOAD: begin
              ram_re_s   = 1'b1;
              ram_addr_s = addr;
              tag_nxt_s  = TAG_RDATA;
            end
            OP_STORE: begin
              ram_we_s    = 1'b1;
              ram_addr_s  = addr;
              ram_wdata_s = wdata;
            end
            OP_PUSH: begin
              if (push_ok(sp_r, LEN_PUSH)) begin
                ram_we_s    = 1'b1;
                ram_wdata_s = wdata;
                sp_nxt_s    = sp_r - SP_ONE;
              end else begin
                ovf_set_s = 1'b1;
              end
            end
            OP_POP: begin
              if (pop_ok(sp_r, LEN_POP)) begin
                ram_re_s   = 1'b1;
                ram_addr_s = sp_up_s;
                tag_nxt_s  = TAG_RDATA;
                sp_nxt_s   = sp_up_s;
              end else begin
                unf_set_s = 1'b1;
              end
            end
            OP_CALL, OP_INT: begin
              if (push_ok(sp_r, (op_e'(op_code) == OP_INT) ? LEN_INT : LEN_CALL)) begin
                ram_we_s    = 1'b1;
                ram_wdata_s = pc_in[PC_W-1:DATA_W];
                sp_nxt_s    = sp_r - SP_ONE;
                state_nxt_s = ST_PUSH1;
              end else begin
                ovf_set_s = 1'b1;
              end
            end
            OP_RET: begin
              if (pop_ok(sp_r, LEN_RET)) begin
                ram_re_s    = 1'b1;
                ram_addr_s  = sp_up_s;
                tag_nxt_s   = TAG_LO;
                sp_nxt_s    = sp_up_s;
                state_nxt_s = ST_POP2;
              end else begin
                unf_set_s = 1'b1;
              end
            end
            OP_RTI: begin
              if (pop_ok(sp_r, LEN_RTI)) begin
                ram_re_s    = 1'b1;
                ram_addr_s  = sp_up_s;
                tag_nxt_s   = TAG_CCR;
                sp_nxt_s    = sp_up_s;
                state_nxt_s = ST_POP1;
              end else begin
                unf_set_s = 1'b1;
              end
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_PUSH1: begin
        ram_we_s    = 1'b1;
        ram_wdata_s = pc_lo_r;
        sp_nxt_s    = sp_r - SP_ONE;
        state_nxt_s = int_frame_r ? ST_PUSH2 : ST_IDLE;
      end
      ST_PUSH2: begin
        ram_we_s    = 1'b1;
        ram_wdata_s = {{(DATA_W-CCR_W){1'b0}}, ccr_r};
        sp_nxt_s    = sp_r - SP_ONE;
        state_nxt_s = ST_IDLE;
      end
      ST_POP1: begin
        ram_re_s    = 1'b1;
        ram_addr_s  = sp_up_s;
        tag_nxt_s   = TAG_LO;
        sp_nxt_s    = sp_up_s;
        state_nxt_s = ST_POP2;
      end
      ST_POP2: begin
        ram_re_s    = 1'b1;
        ram_addr_s  = sp_up_s;
        tag_nxt_s   = int_frame_r ? TAG_HI_CCR : TAG_HI;
        sp_nxt_s    = sp_up_s;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, SP, ready and sticky bound-violation flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      tag_r         <= TAG_NONE;
      sp_r          <= SP_RST;
      ready_r       <= 1'b1;
      ovf_r         <= 1'b0;
      unf_r         <= 1'b0;
      rdata_valid_r <= 1'b0;
      pc_valid_r    <= 1'b0;
      ccr_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      tag_r         <= tag_nxt_s;
      sp_r          <= sp_nxt_s;
      ready_r       <= (state_nxt_s == ST_IDLE);
      ovf_r         <= ovf_r | ovf_set_s;
      unf_r         <= unf_r | unf_set_s;
      rdata_valid_r <= (tag_nxt_s == TAG_RDATA);
      pc_valid_r    <= (tag_nxt_s == TAG_HI) || (tag_nxt_s == TAG_HI_CCR);
      ccr_valid_r   <= (tag_nxt_s == TAG_HI_CCR);
    end
  end

  // Capture frame operands at accept so later words use stable values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_lo_r     <= {DATA_W{1'b0}};
      ccr_r       <= {CCR_W{1'b0}};
      int_frame_r <= 1'b0;
    end else if (accept_s) begin
      pc_lo_r     <= pc_in[DATA_W-1:0];
      ccr_r       <= ccr_in;
      int_frame_r <= (op_e'(op_code) == OP_INT) || (op_e'(op_code) == OP_RTI);
    end
  end

  // Route arriving read data into staging/hold registers by its tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lo_r      <= {DATA_W{1'b0}};
      ccr_stage_r  <= {CCR_W{1'b0}};
      rdata_hold_r <= {DATA_W{1'b0}};
      pc_hold_r    <= {PC_W{1'b0}};
      ccr_hold_r   <= {CCR_W{1'b0}};
    end else begin
      case (tag_r)
        TAG_RDATA:  rdata_hold_r <= ram_q_s;
        TAG_CCR:    ccr_stage_r  <= ram_q_s[CCR_W-1:0];
        TAG_LO:     rd_lo_r      <= ram_q_s;
        TAG_HI:     pc_hold_r    <= {ram_q_s, rd_lo_r};
        TAG_HI_CCR: begin
          pc_hold_r  <= {ram_q_s, rd_lo_r};
          ccr_hold_r <= ccr_stage_r;
        end
        default: begin
          rd_lo_r <= rd_lo_r;
        end
      endcase
    end
  end

  // Results come straight from the RAM register on the pulse, then hold.
  assign rdata         = rdata_valid_r ? ram_q_s : rdata_hold_r;
  assign pc_out        = pc_valid_r ? {ram_q_s, rd_lo_r} : pc_hold_r;
  assign ccr_out       = ccr_valid_r ? ccr_stage_r : ccr_hold_r;
  assign rdata_valid   = rdata_valid_r;
  assign pc_out_valid  = pc_valid_r;
  assign ccr_out_valid = ccr_valid_r;
  assign op_ready      = ready_r;
  assign sp_out        = sp_r;
  assign stack_ovf     = ovf_r;
  assign stack_unf     = unf_r;

endmodule

// File: tb/tb_stack_data_memory.sv
// Bench for stack_data_memory: frame-level model with per-cycle compare, plus literal checks.
module tb_stack_data_memory;
  import stack_mem_pkg::*;

  localparam int SPI = 2048;
  localparam int NC  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op_code = 4'd0;
  logic [11:0] addr = 12'd0;
  logic [15:0] wdata = 16'd0;
  logic [31:0] pc_in = 32'd0;
  logic [2:0]  ccr_in = 3'd0;
  logic        op_ready, rdata_valid, pc_out_valid, ccr_out_valid, stack_ovf, stack_unf;
  logic [15:0] rdata;
  logic [31:0] pc_out;
  logic [2:0]  ccr_out;
  logic [11:0] sp_out;

  logic        v0 = 1'b0;
  logic [3:0]  oc0 = 4'd0;
  logic [11:0] a0 = 12'd0;
  logic [15:0] d0 = 16'd0;
  logic [31:0] pc0 = 32'd0;
  logic        rdy0, rdv0, pcov0, ccrov0, ovf0, unf0;
  logic [15:0] rd0;
  logic [31:0] pco0;
  logic [2:0]  ccro0;
  logic [11:0] sp0;

  stack_data_memory #(.SP_INIT(SPI)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .addr(addr), .wdata(wdata), .pc_in(pc_in), .ccr_in(ccr_in), .rdata(rdata),
    .rdata_valid(rdata_valid), .pc_out(pc_out), .pc_out_valid(pc_out_valid),
    .ccr_out(ccr_out), .ccr_out_valid(ccr_out_valid), .sp_out(sp_out),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  stack_data_memory #(.SP_INIT(0)) dut0 (
    .clk(clk), .rst(rst), .op_valid(v0), .op_ready(rdy0), .op_code(oc0),
    .addr(a0), .wdata(d0), .pc_in(pc0), .ccr_in(3'd0), .rdata(rd0),
    .rdata_valid(rdv0), .pc_out(pco0), .pc_out_valid(pcov0),
    .ccr_out(ccro0), .ccr_out_valid(ccrov0), .sp_out(sp0),
    .stack_ovf(ovf0), .stack_unf(unf0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Frame-level model: memory image, SP, sticky flags, and per-cycle expectations.
  logic [15:0] mmem [0:NC-1];
  int          msp = SPI;
  logic        movf = 1'b0, munf = 1'b0;
  bit          exp_rv [0:NC-1];
  bit          exp_pv [0:NC-1];
  bit          exp_cv [0:NC-1];
  bit          exp_ready [0:NC-1];
  logic [15:0] exp_rd [0:NC-1];
  logic [31:0] exp_pc [0:NC-1];
  logic [2:0]  exp_ccr [0:NC-1];
  logic [15:0] last_rd = 16'd0;
  logic [31:0] last_pc = 32'd0;
  logic [2:0]  last_ccr = 3'd0;

  task automatic model_accept(input op_e op, input logic [11:0] a, input logic [15:0] d,
                              input logic [31:0] pc, input logic [2:0] cc, input int t);
    case (op)
      OP_LOAD:  begin exp_rv[t+1] = 1'b1; exp_rd[t+1] = mmem[a]; end
      OP_STORE: mmem[a] = d;
      OP_PUSH:  begin mmem[msp] = d; msp = msp - 1; end
      OP_POP: begin
        if (msp + 1 <= SPI) begin
          msp = msp + 1; exp_rv[t+1] = 1'b1; exp_rd[t+1] = mmem[msp];
        end else munf = 1'b1;
      end
      OP_CALL: begin
        if (msp >= 1) begin
          mmem[msp] = pc[31:16]; mmem[msp-1] = pc[15:0]; msp = msp - 2;
          exp_ready[t+1] = 1'b0;
        end else movf = 1'b1;
      end
      OP_RET: begin
        if (msp + 2 <= SPI) begin
          exp_pv[t+2] = 1'b1; exp_pc[t+2] = {mmem[msp+2], mmem[msp+1]}; msp = msp + 2;
          exp_ready[t+1] = 1'b0;
        end else munf = 1'b1;
      end
      OP_INT: begin
        if (msp >= 2) begin
          mmem[msp] = pc[31:16]; mmem[msp-1] = pc[15:0]; mmem[msp-2] = {13'd0, cc};
          msp = msp - 3; exp_ready[t+1] = 1'b0; exp_ready[t+2] = 1'b0;
        end else movf = 1'b1;
      end
      OP_RTI: begin
        if (msp + 3 <= SPI) begin
          exp_cv[t+3] = 1'b1; exp_ccr[t+3] = mmem[msp+1][2:0];
          exp_pv[t+3] = 1'b1; exp_pc[t+3] = {mmem[msp+3], mmem[msp+2]};
          msp = msp + 3; exp_ready[t+1] = 1'b0; exp_ready[t+2] = 1'b0;
        end else munf = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Per-cycle compare of the main DUT against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      last_rd = 16'd0; last_pc = 32'd0; last_ccr = 3'd0;
      chk("rst_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_sp", {20'd0, sp_out}, SPI);
      chk("rst_valids", {29'd0, rdata_valid, pc_out_valid, ccr_out_valid}, 32'd0);
      chk("rst_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
      chk("rst_data", {13'd0, ccr_out, rdata} | pc_out, 32'd0);
    end else if (cyc < NC) begin
      if (exp_rv[cyc]) last_rd = exp_rd[cyc];
      if (exp_pv[cyc]) last_pc = exp_pc[cyc];
      if (exp_cv[cyc]) last_ccr = exp_ccr[cyc];
      chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, exp_rv[cyc]});
      chk("rdata", {16'd0, rdata}, {16'd0, last_rd});
      chk("pc_out_valid", {31'd0, pc_out_valid}, {31'd0, exp_pv[cyc]});
      chk("pc_out", pc_out, last_pc);
      chk("ccr_out_valid", {31'd0, ccr_out_valid}, {31'd0, exp_cv[cyc]});
      chk("ccr_out", {29'd0, ccr_out}, {29'd0, last_ccr});
      chk("op_ready", {31'd0, op_ready}, {31'd0, exp_ready[cyc]});
      if (exp_ready[cyc]) chk("sp_out", {20'd0, sp_out}, msp);
      chk("flags", {30'd0, stack_ovf, stack_unf}, {30'd0, movf, munf});
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Present an op, hold it until accepted (bounded), update the model, then drop it.
  task automatic do_op(input op_e op, input logic [11:0] a, input logic [15:0] d,
                       input logic [31:0] pc, input logic [2:0] cc);
    int guard;
    op_valid = 1'b1; op_code = op; addr = a; wdata = d; pc_in = pc; ccr_in = cc;
    guard = 0;
    while (op_ready !== 1'b1 && guard < 20) begin step(); guard++; end
    chk("accept_wait", {31'd0, op_ready}, 32'd1);
    if (op_ready === 1'b1) model_accept(op, a, d, pc, cc, cyc);
    step();
    op_valid = 1'b0; op_code = OP_NOP;
  endtask

  task automatic op0(input op_e op, input logic [11:0] a, input logic [15:0] d, input logic [31:0] pc);
    int guard;
    v0 = 1'b1; oc0 = op; a0 = a; d0 = d; pc0 = pc;
    guard = 0;
    while (rdy0 !== 1'b1 && guard < 20) begin step(); guard++; end
    chk("accept_wait0", {31'd0, rdy0}, 32'd1);
    step();
    v0 = 1'b0; oc0 = OP_NOP;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) exp_ready[i] = 1'b1;
    for (int i = 0; i < NC; i++) mmem[i] = 16'd0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    chk("init_sp", {20'd0, sp_out}, 32'd2048);

    // 1: push/push/pop/pop
    do_op(OP_PUSH, 12'd0, 16'hAAAA, 32'd0, 3'd0);
    chk("t1_sp_a", {20'd0, sp_out}, 32'd2047);
    do_op(OP_PUSH, 12'd0, 16'h5555, 32'd0, 3'd0);
    chk("t1_sp_b", {20'd0, sp_out}, 32'd2046);
    do_op(OP_POP, 12'd0, 16'd0, 32'd0, 3'd0);
    chk("t1_pop1", {15'd0, rdata_valid, rdata}, {15'd0, 1'b1, 16'h5555});
    do_op(OP_POP, 12'd0, 16'd0, 32'd0, 3'd0);
    chk("t1_pop2", {15'd0, rdata_valid, rdata}, {15'd0, 1'b1, 16'hAAAA});
    chk("t1_sp_c", {20'd0, sp_out}, 32'd2048);

    // 2: CALL / RET
    do_op(OP_CALL, 12'd0, 16'd0, 32'h0001_0200, 3'd0);
    chk("t2_busy", {31'd0, op_ready}, 32'd0);
    step();
    chk("t2_ready", {31'd0, op_ready}, 32'd1);
    chk("t2_sp", {20'd0, sp_out}, 32'd2046);
    do_op(OP_LOAD, 12'd2048, 16'd0, 32'd0, 3'd0);
    chk("t2_hi", {16'd0, rdata}, 32'h0001);
    do_op(OP_LOAD, 12'd2047, 16'd0, 32'd0, 3'd0);
    chk("t2_lo", {16'd0, rdata}, 32'h0200);
    do_op(OP_RET, 12'd0, 16'd0, 32'd0, 3'd0);
    chk("t2_ret_busy", {30'd0, op_ready, pc_out_valid}, 32'd0);
    step();
    chk("t2_pcv", {31'd0, pc_out_valid}, 32'd1);
    chk("t2_pc", pc_out, 32'h0001_0200);
    chk("t2_sp2", {20'd0, sp_out}, 32'd2048);

    // 3: INT / RTI
    do_op(OP_INT, 12'd0, 16'd0, 32'h0000_0010, 3'b101);
    chk("t3_busy1", {31'd0, op_ready}, 32'd0);
    step();
    chk("t3_busy2", {31'd0, op_ready}, 32'd0);
    step();
    chk("t3_ready", {31'd0, op_ready}, 32'd1);
    chk("t3_sp", {20'd0, sp_out}, 32'd2045);
    do_op(OP_LOAD, 12'd2046, 16'd0, 32'd0, 3'd0);
    chk("t3_ccrword", {16'd0, rdata}, 32'h0005);
    do_op(OP_RTI, 12'd0, 16'd0, 32'd0, 3'd0);
    step(); step();
    chk("t3_valids", {30'd0, pc_out_valid, ccr_out_valid}, 32'd3);
    chk("t3_pc", pc_out, 32'h0000_0010);
    chk("t3_ccr", {29'd0, ccr_out}, 32'd5);
    chk("t3_sp2", {20'd0, sp_out}, 32'd2048);

    // 4: pop on empty stack
    do_op(OP_POP, 12'd0, 16'd0, 32'd0, 3'd0);
    chk("t4_unf", {30'd0, rdata_valid, stack_unf}, 32'd1);
    chk("t4_sp", {20'd0, sp_out}, 32'd2048);

    // 5: store/load, then op held across a busy frame
    do_op(OP_STORE, 12'h123, 16'hBEEF, 32'd0, 3'd0);
    do_op(OP_LOAD, 12'h123, 16'd0, 32'd0, 3'd0);
    chk("t5_load", {15'd0, rdata_valid, rdata}, {15'd0, 1'b1, 16'hBEEF});
    do_op(OP_CALL, 12'd0, 16'd0, 32'h1234_5678, 3'd0);
    do_op(OP_PUSH, 12'd0, 16'h4242, 32'd0, 3'd0);
    chk("t5_held_sp", {20'd0, sp_out}, 32'd2045);
    do_op(OP_POP, 12'd0, 16'd0, 32'd0, 3'd0);
    chk("t5_pop", {16'd0, rdata}, 32'h4242);
    do_op(OP_RET, 12'd0, 16'd0, 32'd0, 3'd0);
    step();
    chk("t5_ret", pc_out, 32'h1234_5678);

    // 6: reset during an INT frame
    do_op(OP_INT, 12'd0, 16'd0, 32'hCAFE_0001, 3'd2);
    rst = 1'b0;
    msp = SPI; movf = 1'b0; munf = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_rv[cyc+i] = 1'b0; exp_pv[cyc+i] = 1'b0; exp_cv[cyc+i] = 1'b0; exp_ready[cyc+i] = 1'b1;
    end
    #1;
    chk("t6_sp", {20'd0, sp_out}, 32'd2048);
    chk("t6_ready", {31'd0, op_ready}, 32'd1);
    chk("t6_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
    step(); step();
    rst = 1'b1;
    step();
    do_op(OP_PUSH, 12'd0, 16'h7777, 32'd0, 3'd0);
    chk("t6_push_sp", {20'd0, sp_out}, 32'd2047);
    do_op(OP_POP, 12'd0, 16'd0, 32'd0, 3'd0);
    chk("t6_pop", {16'd0, rdata}, 32'h7777);

    // SP_INIT = 0 build: CALL overflows and leaves RAM untouched
    chk("z_sp_init", {20'd0, sp0}, 32'd0);
    op0(OP_STORE, 12'd0, 16'h1234, 32'd0);
    op0(OP_STORE, 12'hFFF, 16'h5678, 32'd0);
    op0(OP_CALL, 12'd0, 16'd0, 32'hDEAD_BEEF);
    chk("z_ovf", {31'd0, ovf0}, 32'd1);
    chk("z_sp", {20'd0, sp0}, 32'd0);
    chk("z_ready", {31'd0, rdy0}, 32'd1);
    op0(OP_LOAD, 12'd0, 16'd0, 32'd0);
    chk("z_mem0", {15'd0, rdv0, rd0}, {15'd0, 1'b1, 16'h1234});
    op0(OP_LOAD, 12'hFFF, 16'd0, 32'd0);
    chk("z_memfff", {16'd0, rd0}, 32'h5678);
    op0(OP_POP, 12'd0, 16'd0, 32'd0);
    chk("z_unf", {30'd0, rdv0, unf0}, 32'd1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
